// File: rtl/spi_reg_bank.sv
// Byte-serial register bank behind an SPI slave: MSB-first bytes are grouped into
// WIDTH-bit words, committed to an indexed register and read back a byte at a time.
module spi_reg_bank #(
    parameter logic [7:0]          BASE_ADDR = 8'h00,
    parameter int                  NUM_REGS  = 4,
    parameter int                  BYTES     = 2,
    parameter int                  AUTO_INC  = 1,
    parameter logic [NUM_REGS-1:0] AUTOCLR   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    addr,
    input  logic [7:0]                    data,
    input  logic                          first,
    input  logic                          strobe,
    input  logic [NUM_REGS*8*BYTES-1:0]   rst_val,
    output logic [NUM_REGS*8*BYTES-1:0]   out_val,
    output logic [NUM_REGS-1:0]           out_stb,
    output logic [7:0]                    rd_data
);
    localparam int WIDTH = 8 * BYTES;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int OW    = ($clog2(NUM_REGS + 1) > 0) ? $clog2(NUM_REGS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    localparam logic [OW-1:0] SAT  = OW'(NUM_REGS);
    localparam logic [7:0]    NR8  = 8'(NUM_REGS);

    logic [CW-1:0]                      r_byte_cnt, w_cnt;
    logic [OW-1:0]                      r_reg_ofs, w_ofs, w_ofs_nxt;
    logic [WIDTH-1:0]                   r_acc, w_group;
    logic [NUM_REGS-1:0]                r_stb, w_hit;
    logic [NUM_REGS-1:0][WIDTH-1:0]     r_val, w_rst_v;
    logic [7:0]                         w_diff, w_idx, w_rd_idx, w_rd;
    logic                               w_last, w_commit;

    assign w_rst_v = rst_val;
    assign out_val = r_val;
    assign out_stb = r_stb;
    assign rd_data = w_rd;

    // A first-qualified byte restarts the transaction regardless of counter state.
    always_comb begin
        w_cnt     = first ? '0 : r_byte_cnt;
        w_ofs     = first ? '0 : r_reg_ofs;
        w_diff    = addr - BASE_ADDR;
        w_idx     = w_diff + 8'(w_ofs);
        w_group   = ((first ? '0 : r_acc) << 8) | WIDTH'(data);
        w_last    = (w_cnt == LAST);
        w_commit  = strobe && w_last && (w_ofs != SAT) && (w_idx < NR8);
        w_ofs_nxt = ((AUTO_INC != 0) && (w_ofs != SAT)) ? w_ofs + OW'(1) : w_ofs;
        w_hit     = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_hit[i] = w_commit && (w_idx == 8'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_reg_ofs  <= '0;
            r_acc      <= '0;
        end else if (strobe) begin
            r_acc      <= w_last ? '0 : w_group;
            r_byte_cnt <= w_last ? '0 : w_cnt + CW'(1);
            r_reg_ofs  <= w_last ? w_ofs_nxt : w_ofs;
        end
    end

    // A fresh commit outranks the self-clear reload of the previous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= w_rst_v;
            r_stb <= '0;
        end else begin
            r_stb <= w_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i])
                    r_val[i] <= w_group;
                else if (AUTOCLR[i] && r_stb[i])
                    r_val[i] <= w_rst_v[i];
            end
        end
    end

    always_comb begin
        w_rd_idx = w_diff + 8'(r_reg_ofs);
        w_rd     = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_rd_idx == 8'(i))
                for (int b = 0; b < BYTES; b++)
                    if (r_byte_cnt == CW'(b))
                        w_rd = r_val[i][WIDTH-1-8*b -: 8];
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized bench for spi_reg_bank: two instances (self-clear off / on reg0)
// compared every cycle against a transaction-level byte-position model.
module tb_spi_reg_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = 8'h10, data = 8'h00;
    logic        first = 1'b0, strobe = 1'b0;
    logic [63:0] rst0, rst1, ov0, ov1;
    logic [3:0]  os0, os1;
    logic [7:0]  rd0, rd1;

    int checks = 0;
    int errors = 0;

    logic [15:0] mv0 [4];
    logic [15:0] mv1 [4];
    logic [3:0]  mstb;
    int          mn;
    logic [7:0]  mq [$];

    always #5 clk = ~clk;

    spi_reg_bank #(.BASE_ADDR(8'h10), .NUM_REGS(4), .BYTES(2), .AUTO_INC(1), .AUTOCLR(4'b0000)) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .first(first), .strobe(strobe),
        .rst_val(rst0), .out_val(ov0), .out_stb(os0), .rd_data(rd0));

    spi_reg_bank #(.BASE_ADDR(8'h10), .NUM_REGS(4), .BYTES(2), .AUTO_INC(1), .AUTOCLR(4'b0001)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .first(first), .strobe(strobe),
        .rst_val(rst1), .out_val(ov1), .out_stb(os1), .rd_data(rd1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int which);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = which ? mv1[i] : mv0[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] a, input int which);
        int         gs;
        logic [7:0] idx;
        logic [15:0] v;
        gs  = (mn / 2 > 4) ? 4 : mn / 2;
        idx = a - 8'h10 + 8'(gs);
        if (idx >= 8'd4) return 8'h00;
        v = which ? mv1[idx[1:0]] : mv0[idx[1:0]];
        return (mn % 2 == 0) ? v[15:8] : v[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv0[i] = rst0[i*16 +: 16];
            mv1[i] = rst1[i*16 +: 16];
        end
        mstb = '0;
        mn   = 0;
        mq.delete();
    endtask

    // Byte position since the last first (or reset) fixes group and byte-in-group.
    task automatic model_step(input logic s, input logic f, input logic [7:0] d, input logic [7:0] a);
        logic [3:0]  hit;
        logic [15:0] gv;
        logic [7:0]  idx;
        int          pos, g;
        hit = '0;
        gv  = '0;
        if (s) begin
            pos = f ? 0 : mn;
            if (f) mq.delete();
            mq.push_back(d);
            g = pos / 2;
            if (pos % 2 == 1) begin
                gv = {mq[0], mq[1]};
                mq.delete();
                if (g < 4) begin
                    idx = a - 8'h10 + 8'(g);
                    if (idx < 8'd4) hit[idx[1:0]] = 1'b1;
                end
            end
            mn = (pos + 1 > 100) ? 100 - (pos + 1) % 2 : pos + 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (mstb[i] && i == 0) mv1[i] = rst1[i*16 +: 16];
            if (hit[i]) begin
                mv0[i] = gv;
                mv1[i] = gv;
            end
        end
        mstb = hit;
    endtask

    task automatic cyc(input logic s, input logic f, input logic [7:0] d, input logic [7:0] a);
        strobe = s; first = f; data = d; addr = a;
        #1;
        chk("rd0", 64'(rd0), 64'(exp_rd(a, 0)));
        chk("rd1", 64'(rd1), 64'(exp_rd(a, 1)));
        @(posedge clk);
        model_step(s, f, d, a);
        @(negedge clk);
        chk("val0", ov0, pack(0));
        chk("val1", ov1, pack(1));
        chk("stb0", 64'(os0), 64'(mstb));
        chk("stb1", 64'(os1), 64'(mstb));
        strobe = 1'b0; first = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; strobe = 1'b0; first = 1'b0;
        #1;
        chk("rst_val0", ov0, rst0);
        chk("rst_val1", ov1, rst1);
        chk("rst_stb", 64'({os1, os0}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [63:0] snap;
        logic [7:0]  ra;
        logic        s, f;
        rst0 = {16'($urandom), 16'($urandom), 16'($urandom), 16'h1234};
        rst1 = {rst0[63:16], 16'h0000};
        model_reset();
        @(negedge clk);
        do_reset();

        // Read-back straight out of reset: byte 0 then byte 1 of reg0.
        cyc(0, 0, 8'h00, 8'h10);
        chk("rb_b0", 64'(rd0), 64'h12);
        cyc(1, 1, 8'h99, 8'h10);
        #1 chk("rb_b1", 64'(rd0), 64'h34);
        cyc(1, 0, 8'h77, 8'h10);
        chk("rb_commit", 64'(ov0[15:0]), 64'h9977);

        // Single write to reg1.
        snap = ov0;
        cyc(1, 1, 8'hAB, 8'h11);
        cyc(1, 0, 8'hCD, 8'h11);
        chk("w_reg1", 64'(ov0[31:16]), 64'hABCD);
        chk("w_stb", 64'(os0), 64'b0010);
        chk("w_others", {ov0[63:32], ov0[15:0]}, {snap[63:32], snap[15:0]});
        cyc(0, 0, 8'h00, 8'h11);
        chk("w_stb_off", 64'(os0), 64'h0);

        // Burst with saturation past reg3.
        for (int i = 1; i <= 6; i++) begin
            cyc(1, i == 1, 8'(i), 8'h12);
            if (i == 2) chk("b_stb2", 64'(os0), 64'b0100);
            if (i == 4) chk("b_stb3", 64'(os0), 64'b1000);
            if (i == 6) chk("b_drop", 64'(os0), 64'h0);
        end
        chk("b_reg23", 64'(ov0[63:32]), 64'h0304_0102);

        // Out-of-range address.
        snap = ov0;
        cyc(1, 1, 8'hFF, 8'h20);
        cyc(1, 0, 8'hFF, 8'h20);
        chk("oor_val", ov0, snap);
        chk("oor_stb", 64'(os0), 64'h0);
        #1 chk("oor_rd", 64'(rd0), 64'h00);

        // Reset interrupts a partial group.
        cyc(1, 1, 8'h55, 8'h10);
        do_reset();
        cyc(1, 1, 8'h66, 8'h10);
        chk("rm_nocommit", 64'(os0), 64'h0);
        cyc(1, 0, 8'h77, 8'h10);
        chk("rm_commit", 64'(ov0[15:0]), 64'h6677);

        // Self-clearing reg0 on the second instance.
        cyc(1, 1, 8'hBE, 8'h10);
        cyc(1, 0, 8'hEF, 8'h10);
        chk("ac_hold", 64'(ov1[15:0]), 64'hBEEF);
        chk("ac_stb", 64'(os1), 64'b0001);
        cyc(0, 0, 8'h00, 8'h10);
        chk("ac_clear", 64'(ov1[15:0]), 64'h0000);
        chk("ac_keep0", 64'(ov0[15:0]), 64'hBEEF);

        // Back-to-back commits to the self-clearing register.
        cyc(1, 1, 8'h11, 8'h10);
        cyc(1, 0, 8'h22, 8'h10);
        cyc(1, 1, 8'h33, 8'h10);
        cyc(1, 0, 8'h44, 8'h10);
        chk("ac_win", 64'(ov1[15:0]), 64'h3344);

        ra = 8'h10;
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            s = 1'($urandom_range(0, 2) != 0);
            f = s && ($urandom_range(0, 5) == 0);
            if (f) begin
                case ($urandom_range(0, 7))
                    0: ra = 8'h0E;
                    1: ra = 8'h0F;
                    2: ra = 8'h10;
                    3: ra = 8'h11;
                    4: ra = 8'h12;
                    5: ra = 8'h13;
                    6: ra = 8'h20;
                    default: ra = 8'hFF;
                endcase
            end
            cyc(s, f, 8'($urandom), ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
